stride_prefetch_buffer: RTL and testbench

Parametrised successor to the next-line prefetch buffer that sits beside the L1 data cache. On every demand miss it looks up a DEPTH-entry, MRU-ordered buffer of prefetched line addresses and reports hit or miss. It trains a single-stream stride detector and issues up to DEGREE prefetch requests to the memory side over a valid/ready handshake. The miss-side request/response pair replaces the old free-running `cache_miss`/`prefetch_hit` pair.

---
 rtl/prefetch_pkg.sv | 31 +++
 rtl/prefetch_tag_cam.sv | 65 ++++++
 rtl/stride_prefetch_buffer.sv | 112 +++++++++++
 tb/tb_stride_prefetch_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the stride prefetch buffer: FSM states,
// parameter derivations and line/byte-address conversions.
package prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        PROMOTE = 2'd2,
        ISSUE   = 2'd3
    } pf_state_e;

    // Conversions work on a wide container; callers size-cast to their own widths.
    localparam int MAX_W = 64;

    function automatic int off_w(input int block_bytes);
        return $clog2(block_bytes);
    endfunction

    function automatic int line_w(input int addr_w, input int block_bytes);
        return addr_w - $clog2(block_bytes);
    endfunction

    function automatic logic [MAX_W-1:0] addr_to_line(input logic [MAX_W-1:0] addr, input int off);
        return addr >> off;
    endfunction

    function automatic logic [MAX_W-1:0] line_to_addr(input logic [MAX_W-1:0] line, input int off);
        return line << off;
    endfunction

endpackage

// File: rtl/prefetch_tag_cam.sv
// MRU-ordered line-address store: insert at entry 0, promote a hit to entry 0,
// lowest-index demand match plus a candidate-present match.
module prefetch_tag_cam #(
    parameter int DEPTH  = 8,
    parameter int LINE_W = 28,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_en,
    input  logic [LINE_W-1:0] ins_line,
    input  logic              promote_en,
    input  logic [IDX_W-1:0]  promote_idx,
    input  logic [LINE_W-1:0] dmd_line,
    output logic              dmd_hit,
    output logic [IDX_W-1:0]  dmd_idx,
    input  logic [LINE_W-1:0] cand_line,
    output logic              cand_present
);

    logic [DEPTH-1:0]             vld;
    logic [DEPTH-1:0][LINE_W-1:0] tag;
    logic [DEPTH-1:0]             dmd_match;
    logic [DEPTH-1:0]             cand_match;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign dmd_match[i]  = vld[i] && (tag[i] == dmd_line);
        assign cand_match[i] = vld[i] && (tag[i] == cand_line);
    end

    assign dmd_hit      = |dmd_match;
    assign cand_present = |cand_match;

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        dmd_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (dmd_match[i]) dmd_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            tag <= '0;
        end else if (ins_en) begin
            for (int i = 1; i < DEPTH; i++) begin
                tag[i] <= tag[i-1];
                vld[i] <= vld[i-1];
            end
            tag[0] <= ins_line;
            vld[0] <= 1'b1;
        end else if (promote_en) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (i <= int'(promote_idx)) begin
                    tag[i] <= tag[i-1];
                    vld[i] <= vld[i-1];
                end
            end
            tag[0] <= tag[promote_idx];
            vld[0] <= vld[promote_idx];
        end
    end

endmodule

// File: rtl/stride_prefetch_buffer.sv
// Demand-miss lookup against a prefetched-line buffer, single-stream stride
// training and DEGREE-deep prefetch issue over a valid/ready request port.
module stride_prefetch_buffer
    import prefetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_BYTES = 16,
    parameter int DEPTH       = 8,
    parameter int DEGREE      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              pf_req_valid,
    output logic [ADDR_W-1:0] pf_req_addr,
    input  logic              pf_req_ready
);

    localparam int OFF_W  = off_w(BLOCK_BYTES);
    localparam int LINE_W = line_w(ADDR_W, BLOCK_BYTES);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int K_W    = $clog2(DEGREE + 1);

    pf_state_e         state, state_nxt;
    logic [LINE_W-1:0] l_line, last_line, last_delta, step, cand;
    logic [LINE_W-1:0] delta, step_nxt;
    logic [K_W-1:0]    k;
    logic              conf, k_last, advance, ins_en, promote_en;
    logic              dmd_hit, cand_present;
    logic [IDX_W-1:0]  dmd_idx;

    prefetch_tag_cam #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W),
        .IDX_W  (IDX_W)
    ) u_cam (
        .clk          (clk),
        .rst          (rst),
        .ins_en       (ins_en),
        .ins_line     (cand),
        .promote_en   (promote_en),
        .promote_idx  (dmd_idx),
        .dmd_line     (l_line),
        .dmd_hit      (dmd_hit),
        .dmd_idx      (dmd_idx),
        .cand_line    (cand),
        .cand_present (cand_present)
    );

    always_comb begin
        delta        = l_line - last_line;
        conf         = (delta == last_delta) && (delta != '0);
        step_nxt     = conf ? delta : LINE_W'(1);
        k_last       = (k == K_W'(DEGREE));
        miss_ready   = (state == IDLE);
        resp_valid   = (state == LOOKUP);
        resp_hit     = resp_valid && dmd_hit;
        promote_en   = (state == PROMOTE);
        // Present candidates are skipped without a request, so valid never drops mid-stall.
        pf_req_valid = (state == ISSUE) && !cand_present;
        pf_req_addr  = pf_req_valid ? ADDR_W'(line_to_addr(MAX_W'(cand), OFF_W)) : '0;
        advance      = (state == ISSUE) && (cand_present || pf_req_ready);
        ins_en       = pf_req_valid && pf_req_ready && !rst;

        state_nxt = state;
        unique case (state)
            IDLE:    if (miss_valid) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = dmd_hit ? PROMOTE : ISSUE;
            PROMOTE: state_nxt = ISSUE;
            ISSUE:   if (advance && k_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            l_line     <= '0;
            last_line  <= '0;
            last_delta <= '0;
            step       <= '0;
            cand       <= '0;
            k          <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (miss_valid) l_line <= LINE_W'(addr_to_line(MAX_W'(miss_addr), OFF_W));
                end
                LOOKUP: begin
                    last_line  <= l_line;
                    last_delta <= delta;
                    step       <= step_nxt;
                    cand       <= l_line + step_nxt;
                    k          <= K_W'(1);
                end
                ISSUE: begin
                    if (advance) begin
                        k    <= k + K_W'(1);
                        cand <= cand + step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stride_prefetch_buffer.sv
// Scoreboard bench: a queue-based reference model predicts lookup results and
// prefetch addresses; a negedge monitor checks them as the DUT presents them.
module tb_stride_prefetch_buffer;

    localparam int DEPTH  = 8;
    localparam int DEGREE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_valid = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        miss_ready;
    logic        resp_valid;
    logic        resp_hit;
    logic        pf_req_valid;
    logic [31:0] pf_req_addr;
    logic        pf_req_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_ready = 1'b0;

    logic        exp_resp[$];
    logic [31:0] exp_pf[$];
    logic [27:0] mbuf[$];
    logic [27:0] m_last = '0;
    logic [27:0] m_ldelta = '0;

    stride_prefetch_buffer #(
        .ADDR_W      (32),
        .BLOCK_BYTES (16),
        .DEPTH       (DEPTH),
        .DEGREE      (DEGREE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_valid   (miss_valid),
        .miss_addr    (miss_addr),
        .miss_ready   (miss_ready),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .pf_req_valid (pf_req_valid),
        .pf_req_addr  (pf_req_addr),
        .pf_req_ready (pf_req_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: MRU list of lines, front = most recent.
    task automatic model_miss(input logic [31:0] a);
        logic [27:0] l, d, st, c;
        int idx;
        bit present;
        l = a[31:4];
        idx = -1;
        for (int i = 0; i < mbuf.size(); i++) if (idx < 0 && mbuf[i] == l) idx = i;
        exp_resp.push_back(idx >= 0);
        if (idx >= 0) begin
            mbuf.delete(idx);
            mbuf.push_front(l);
        end
        d = l - m_last;
        st = (d == m_ldelta && d != 0) ? d : 28'd1;
        m_ldelta = d;
        m_last = l;
        for (int k = 1; k <= DEGREE; k++) begin
            c = l + 28'(k) * st;
            present = 1'b0;
            for (int i = 0; i < mbuf.size(); i++) if (mbuf[i] == c) present = 1'b1;
            if (!present) begin
                exp_pf.push_back({c, 4'h0});
                mbuf.push_front(c);
                if (mbuf.size() > DEPTH) void'(mbuf.pop_back());
            end
        end
    endtask

    task automatic model_reset();
        exp_resp.delete();
        exp_pf.delete();
        mbuf.delete();
        m_last = '0;
        m_ldelta = '0;
    endtask

    // Monitor: every lookup pulse and every handshake is matched to the model.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (resp_valid) begin
                if (exp_resp.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
                else check("resp_hit", 32'(resp_hit), 32'(exp_resp.pop_front()));
            end
            if (pf_req_valid && pf_req_ready) begin
                if (exp_pf.size() == 0) check("pf_unexpected", pf_req_addr, 32'hDEAD_BEEF);
                else check("pf_req_addr", pf_req_addr, exp_pf.pop_front());
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) pf_req_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        miss_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_miss_ready", 32'(miss_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_hit", 32'(resp_hit), 32'd0);
        check("rst_pf_valid", 32'(pf_req_valid), 32'd0);
        check("rst_pf_addr", pf_req_addr, 32'd0);
    endtask

    // Returns at the negedge of the lookup cycle (T+1).
    task automatic send_miss(input logic [31:0] a);
        int n = 0;
        @(negedge clk);
        miss_valid = 1'b1;
        miss_addr = a;
        while (!miss_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("miss_accept_timeout", 32'(miss_ready), 32'd1);
        model_miss(a);
        @(posedge clk);
        #1 miss_valid = 1'b0;
        @(negedge clk);
        check("resp_latency", 32'(resp_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!miss_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(miss_ready), 32'd1);
        check("pf_drained", 32'(exp_pf.size()), 32'd0);
        check("resp_drained", 32'(exp_resp.size()), 32'd0);
    endtask

    task automatic wait_pf_valid();
        int n = 0;
        while (!pf_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pf_valid_seen", 32'(pf_req_valid), 32'd1);
    endtask

    initial begin
        logic [31:0] held, a;

        // Next-line case, then a hit with promotion and skipped candidate.
        do_reset();
        send_miss(32'h0000_1000);
        @(negedge clk);
        check("issue_latency_valid", 32'(pf_req_valid), 32'd1);
        check("issue_first_addr", pf_req_addr, 32'h0000_1010);
        wait_idle();
        send_miss(32'h0000_1010);
        wait_idle();

        // Stride confirmation over three misses.
        do_reset();
        send_miss(32'h0000_2000);
        wait_idle();
        send_miss(32'h0000_2040);
        wait_idle();
        send_miss(32'h0000_2080);
        wait_idle();

        // Line-address wrap.
        do_reset();
        send_miss(32'hFFFF_FFF0);
        wait_idle();

        // Back-pressure: request holds while a second miss waits.
        do_reset();
        pf_req_ready = 1'b0;
        send_miss(32'h0000_3000);
        miss_valid = 1'b1;
        miss_addr = 32'h0000_3100;
        wait_pf_valid();
        held = pf_req_addr;
        check("stall_first_addr", held, 32'h0000_3010);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(pf_req_valid), 32'd1);
            check("stall_addr", pf_req_addr, held);
            check("stall_miss_ready", 32'(miss_ready), 32'd0);
            check("stall_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 pf_req_ready = 1'b1;
        send_miss(32'h0000_3100);
        wait_idle();

        // Reset during a pending request, handshake coinciding with reset.
        do_reset();
        pf_req_ready = 1'b0;
        send_miss(32'h0000_5000);
        wait_pf_valid();
        @(posedge clk);
        #1;
        rst = 1'b1;
        pf_req_ready = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("abort_pf_valid", 32'(pf_req_valid), 32'd0);
        check("abort_miss_ready", 32'(miss_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        send_miss(32'h0000_5010);
        wait_idle();

        // Randomized mix of strided runs, repeats and scattered lines.
        do_reset();
        rand_ready = 1'b1;
        a = 32'h0000_8000;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: a = 32'h0000_8000 + (32'($urandom_range(0, 31)) << 4);
                1: a = a + (32'($urandom_range(1, 3)) << 4);
                2: a = a + 32'h10;
                default: a = a - (32'($urandom_range(0, 2)) << 4);
            endcase
            a[3:0] = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_miss(a);
        end
        wait_idle();
        rand_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
